// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan arbiter.
package disp_pkg;

    localparam int unsigned DWELL_DEFAULT = 5000;
    localparam int unsigned NIB_W         = 4;
    localparam int unsigned SEG_W         = 7;
    localparam int unsigned WORD_W        = 32;

    typedef enum logic [1:0] {
        DBG  = 2'd0,
        MMIO = 2'd1,
        AUX  = 2'd2,
        NONE = 2'd3
    } src_e;

    // Active-low segments {a,b,c,d,e,f,g}, index 15 first.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    // Index of the highest nonzero nibble; 0 when the word is all zero.
    function automatic logic [2:0] top_nibble(input logic [WORD_W-1:0] word);
        logic [2:0] top;
        top = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (word[NIB_W*i +: NIB_W] != 4'h0) top = 3'(i);
        end
        return top;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/disp_scan_arbiter.sv
// Three-source display arbiter: grants one source per frame and scans its
// 32-bit word across eight digits with PWM brightness and leading-zero blanking.
module disp_scan_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEFAULT
) (
    input  logic              clk_5M,
    input  logic              Rst,
    input  logic              dbg_req,
    input  logic [WORD_W-1:0] dbg_data,
    input  logic              mmio_req,
    input  logic [WORD_W-1:0] mmio_data,
    input  logic              aux_req,
    input  logic [WORD_W-1:0] aux_data,
    input  logic [2:0]        bright,
    input  logic              lz_blank,
    output logic [7:0]        an,
    output logic [SEG_W-1:0]  sev_out,
    output logic [1:0]        active_src,
    output logic              frame_done
);

    localparam int unsigned DWELL_W = 16;
    localparam int unsigned PROD_W  = 20;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    typedef enum logic {
        LOAD = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         digit_q, digit_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [WORD_W-1:0]  snap_q,  snap_d;
    src_e               src_q,   src_d;
    logic               lz_q,    lz_d;
    logic [7:0]         an_q,    an_d;
    logic [SEG_W-1:0]   sev_q,   sev_d;
    logic               fd_q,    fd_d;

    logic [NIB_W-1:0]   nib_c;
    logic [SEG_W-1:0]   seg_c;
    logic [2:0]         top_c;
    logic [PROD_W-1:0]  thr_c;
    logic               lit_c;

    assign nib_c = snap_q[{digit_q, 2'b00} +: NIB_W];
    assign top_c = top_nibble(snap_q);

    // On-time threshold: ((bright+1)*DWELL)/8, widened so DWELL up to 65535 fits.
    assign thr_c = PROD_W'((PROD_W'(bright) + PROD_W'(1)) * PROD_W'(DWELL)) >> 3;
    assign lit_c = PROD_W'(dwell_q) < thr_c;

    seg7_decode u_seg7_decode (
        .nib_i   (nib_c),
        .seg_c_o (seg_c)
    );

    always_ff @(posedge clk_5M) begin
        if (Rst) begin
            state_q <= LOAD;
            digit_q <= 3'd0;
            dwell_q <= '0;
            snap_q  <= '0;
            src_q   <= NONE;
            lz_q    <= 1'b0;
            an_q    <= 8'hFF;
            sev_q   <= 7'h7F;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            dwell_q <= dwell_d;
            snap_q  <= snap_d;
            src_q   <= src_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            sev_q   <= sev_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        dwell_d = dwell_q;
        snap_d  = snap_q;
        src_d   = src_q;
        lz_d    = lz_q;
        an_d    = 8'hFF;
        sev_d   = 7'h7F;
        fd_d    = 1'b0;

        case (state_q)
            LOAD: begin
                state_d = SCAN;
                digit_d = 3'd0;
                dwell_d = '0;
                lz_d    = lz_blank;
                if (dbg_req) begin
                    src_d  = DBG;
                    snap_d = dbg_data;
                end else if (mmio_req) begin
                    src_d  = MMIO;
                    snap_d = mmio_data;
                end else if (aux_req) begin
                    src_d  = AUX;
                    snap_d = aux_data;
                end else begin
                    src_d  = NONE;
                    snap_d = '0;
                end
            end
            SCAN: begin
                sev_d = seg_c;
                if (src_q != NONE && lit_c && !(lz_q && digit_q > top_c)) begin
                    an_d = ~(8'(1) << digit_q);
                end
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    digit_d = digit_q + 3'd1;
                    if (digit_q == 3'd7) state_d = LOAD;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: state_d = LOAD;
        endcase

        // Registered from next state so the pulse lands on the last scan cycle itself.
        fd_d = (state_d == SCAN) && (digit_d == 3'd7) && (dwell_d == DWELL_LAST);
    end

    assign an         = an_q;
    assign sev_out    = sev_q;
    assign active_src = 2'(src_q);
    assign frame_done = fd_q;

endmodule
